// File: rtl/lfsr_pkg.sv
// Shared definitions for the XNOR LFSR pattern generator and checker:
// FSM state encodings, default tap constants and the default-width step function.
package lfsr_pkg;

    typedef enum logic {
        ST_HUNT  = 1'b0,
        ST_CHECK = 1'b1
    } state_t;

    localparam int DEF_WIDTH = 4;
    localparam int DEF_TAP_A = 3;
    localparam int DEF_TAP_B = 2;
    localparam int CNT_W     = 4;

    function automatic logic [DEF_WIDTH-1:0] lfsr_step_word(input logic [DEF_WIDTH-1:0] q);
        return {q[DEF_WIDTH-2:0], ~(q[DEF_TAP_A] ^ q[DEF_TAP_B])};
    endfunction

endpackage

// File: rtl/lfsr_step.sv
// Combinational next-word function of a WIDTH-bit XNOR LFSR with two feedback taps.
module lfsr_step #(
    parameter int WIDTH = 4,
    parameter int TAP_A = 3,
    parameter int TAP_B = 2
) (
    input  logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] nxt
);

    assign nxt = {q[WIDTH-2:0], ~(q[TAP_A] ^ q[TAP_B])};

endmodule

// File: rtl/lfsr_seq_checker.sv
// HUNT/CHECK checker for the XNOR LFSR pattern stream with a flywheel reference.
// Define LFSR_CHK_STUCK_EN to detect the all-ones lockup word (stuck flag).
module lfsr_seq_checker
    import lfsr_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int TAP_A    = DEF_TAP_A,
    parameter int TAP_B    = DEF_TAP_B,
    parameter int LOCK_CNT = 4,
    parameter int LOSS_CNT = 3,
    parameter int ERR_W    = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    input  logic             clr_cnt,
    output logic             locked,
    output logic             err,
    output logic [ERR_W-1:0] err_cnt,
    output logic             stuck,
    output state_t           fsm_state
);

    localparam logic [CNT_W-1:0] LOCK_V = CNT_W'(LOCK_CNT);
    localparam logic [CNT_W-1:0] LOSS_V = CNT_W'(LOSS_CNT);

    state_t             state_q, state_d;
    logic               have_prev_q, have_prev_d;
    logic [WIDTH-1:0]   prev_q, prev_d;
    logic [WIDTH-1:0]   exp_q, exp_d;
    logic [CNT_W-1:0]   match_q, match_d;
    logic [CNT_W-1:0]   miss_q, miss_d;
    logic               err_q, err_d;
    logic [ERR_W-1:0]   err_cnt_q, err_cnt_d;
    logic               err_inc;
    logic               lockup;
    logic [WIDTH-1:0]   pred;
    logic [WIDTH-1:0]   adv_in;
    logic [WIDTH-1:0]   adv;

    // In HUNT the second stepper supplies step(din) for the lock-time seed;
    // in CHECK it advances the flywheel.
    assign adv_in = (state_q == ST_CHECK) ? exp_q : din;

    lfsr_step #(.WIDTH(WIDTH), .TAP_A(TAP_A), .TAP_B(TAP_B)) u_pred (
        .q   (prev_q),
        .nxt (pred)
    );

    lfsr_step #(.WIDTH(WIDTH), .TAP_A(TAP_A), .TAP_B(TAP_B)) u_adv (
        .q   (adv_in),
        .nxt (adv)
    );

`ifdef LFSR_CHK_STUCK_EN
    logic stuck_q;

    assign lockup = din_valid && (&din);

    always_ff @(posedge clk) begin
        if (reset) begin
            stuck_q <= 1'b0;
        end else if (lockup) begin
            stuck_q <= 1'b1;
        end
    end

    assign stuck = stuck_q;
`else
    assign lockup = 1'b0;
    assign stuck  = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        have_prev_d = have_prev_q;
        prev_d      = prev_q;
        exp_d       = exp_q;
        match_d     = match_q;
        miss_d      = miss_q;
        err_d       = 1'b0;
        err_inc     = 1'b0;
        if (din_valid) begin
            case (state_q)
                ST_HUNT: begin
                    prev_d      = din;
                    have_prev_d = 1'b1;
                    if (have_prev_q) begin
                        if ((din == pred) && !lockup) begin
                            match_d = match_q + 1'b1;
                            if (match_d == LOCK_V) begin
                                state_d = ST_CHECK;
                                exp_d   = adv;
                                miss_d  = '0;
                            end
                        end else begin
                            match_d = '0;
                        end
                    end
                end
                ST_CHECK: begin
                    exp_d = adv;
                    if ((din != exp_q) || lockup) begin
                        err_d   = 1'b1;
                        err_inc = 1'b1;
                        miss_d  = miss_q + 1'b1;
                        if (miss_d == LOSS_V) begin
                            state_d = ST_HUNT;
                            prev_d  = din;
                            match_d = '0;
                        end
                    end else begin
                        miss_d = '0;
                    end
                end
            endcase
        end
        // Clear wins over a same-cycle increment; the count saturates at all-ones.
        err_cnt_d = err_cnt_q;
        if (clr_cnt) begin
            err_cnt_d = '0;
        end else if (err_inc && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_HUNT;
            have_prev_q <= 1'b0;
            prev_q      <= '0;
            exp_q       <= '0;
            match_q     <= '0;
            miss_q      <= '0;
            err_q       <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            have_prev_q <= have_prev_d;
            prev_q      <= prev_d;
            exp_q       <= exp_d;
            match_q     <= match_d;
            miss_q      <= miss_d;
            err_q       <= err_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign locked    = (state_q == ST_CHECK);
    assign err       = err_q;
    assign err_cnt   = err_cnt_q;
    assign fsm_state = state_q;

endmodule

// File: tb/tb_lfsr_seq_checker.sv
// Scoreboard bench for lfsr_seq_checker; honours LFSR_CHK_STUCK_EN when defined.
module tb_lfsr_seq_checker;
    import lfsr_pkg::*;

    localparam int W = 12;

    logic       clk;
    logic       reset;
    logic [3:0] din;
    logic       din_valid;
    logic       clr_cnt;
    logic       locked;
    logic       err;
    logic [7:0] err_cnt;
    logic       stuck;
    state_t     fsm_state;

    int checks   = 0;
    int failures = 0;

    logic [W-1:0] exp_q[$];

    // reference model state
    logic       m_check;
    logic       m_have;
    logic [3:0] m_prev;
    logic [3:0] m_exp;
    int         m_match;
    int         m_miss;
    logic       m_err;
    int         m_cnt;
    logic       m_stuck;

    logic [3:0] g;

    lfsr_seq_checker dut (
        .clk       (clk),
        .reset     (reset),
        .din       (din),
        .din_valid (din_valid),
        .clr_cnt   (clr_cnt),
        .locked    (locked),
        .err       (err),
        .err_cnt   (err_cnt),
        .stuck     (stuck),
        .fsm_state (fsm_state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog act=running exp=finished");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [3:0] nxt(input logic [3:0] q);
        logic b;
        b = ~(q[3] ^ q[2]);
        return {q[2:0], b};
    endfunction

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", tag, act, expv, $time);
        end
    endtask

    task automatic model_reset();
        m_check = 1'b0;
        m_have  = 1'b0;
        m_prev  = 4'h0;
        m_exp   = 4'h0;
        m_match = 0;
        m_miss  = 0;
        m_err   = 1'b0;
        m_cnt   = 0;
        m_stuck = 1'b0;
    endtask

    task automatic model_step(input logic [3:0] d, input logic v, input logic c);
        logic lk;
        logic inc;
        lk  = 1'b0;
        inc = 1'b0;
`ifdef LFSR_CHK_STUCK_EN
        lk = (d == 4'hF);
`endif
        m_err = 1'b0;
        if (v) begin
            if (lk) m_stuck = 1'b1;
            if (!m_check) begin
                if (!m_have) begin
                    m_have = 1'b1;
                end else if (d == nxt(m_prev) && !lk) begin
                    m_match++;
                    if (m_match == 4) begin
                        m_check = 1'b1;
                        m_exp   = nxt(d);
                        m_miss  = 0;
                    end
                end else begin
                    m_match = 0;
                end
                m_prev = d;
            end else begin
                if (d != m_exp || lk) begin
                    m_err = 1'b1;
                    inc   = 1'b1;
                    m_miss++;
                    if (m_miss == 3) begin
                        m_check = 1'b0;
                        m_prev  = d;
                        m_match = 0;
                    end
                end else begin
                    m_miss = 0;
                end
                m_exp = nxt(m_exp);
            end
        end
        if (c) m_cnt = 0;
        else if (inc && m_cnt < 255) m_cnt++;
    endtask

    function automatic logic [W-1:0] model_pack();
        return {m_check, m_err, 8'(m_cnt), m_stuck, m_check};
    endfunction

    task automatic compare_out();
        logic [W-1:0] e;
        check("sb_depth", 32'(exp_q.size()), 32'd1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("locked",  {31'd0, locked}, {31'd0, e[11]});
            check("err",     {31'd0, err},    {31'd0, e[10]});
            check("err_cnt", {24'd0, err_cnt}, {24'd0, e[9:2]});
            check("stuck",   {31'd0, stuck},  {31'd0, e[1]});
            check("state",   32'(fsm_state),  {31'd0, e[0]});
        end
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        din_valid = 1'b0;
        clr_cnt   = 1'b0;
        din       = 4'($urandom_range(0, 15));
        model_reset();
        exp_q.push_back(model_pack());
        @(posedge clk);
        #1;
        compare_out();
        reset = 1'b0;
    endtask

    task automatic drive(input logic [3:0] d, input logic v, input logic c);
        din       = d;
        din_valid = v;
        clr_cnt   = c;
        model_step(d, v, c);
        exp_q.push_back(model_pack());
        @(posedge clk);
        #1;
        compare_out();
    endtask

    task automatic send_good();
        g = nxt(g);
        drive(g, 1'b1, 1'b0);
    endtask

    task automatic send_bad(input logic c);
        g = nxt(g);
        drive(g ^ 4'($urandom_range(1, 15)), 1'b1, c);
    endtask

    task automatic gap(input int n);
        for (int i = 0; i < n; i++) drive(4'($urandom_range(0, 15)), 1'b0, 1'b0);
    endtask

    task automatic lock_from_zero();
        g = 4'h0;
        drive(g, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) send_good();
    endtask

    initial begin
        int base;
        int n;
        reset     = 1'b1;
        din       = 4'h0;
        din_valid = 1'b0;
        clr_cnt   = 1'b0;
        g         = 4'h0;
        model_reset();

        // reset state
        do_reset();
        check("rst_locked", {31'd0, locked}, 32'd0);
        check("rst_cnt", {24'd0, err_cnt}, 32'd0);

        // 1: lock on 0000,0001,0011,0111,1110
        g = 4'h0;
        drive(g, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) send_good();
        check("t1_not_yet", {31'd0, locked}, 32'd0);
        send_good();
        check("t1_word", {28'd0, din}, 32'hE);
        check("t1_locked", {31'd0, locked}, 32'd1);
        check("t1_cnt", {24'd0, err_cnt}, 32'd0);

        // 2: one substituted word
        g = nxt(g);
        drive(4'h0, 1'b1, 1'b0);
        check("t2_err", {31'd0, err}, 32'd1);
        check("t2_cnt", {24'd0, err_cnt}, 32'd1);
        check("t2_locked", {31'd0, locked}, 32'd1);
        send_good();
        check("t2_next_word", {28'd0, din}, 32'hB);
        check("t2_err_clr", {31'd0, err}, 32'd0);
        check("t2_still_locked", {31'd0, locked}, 32'd1);

        // 3: loss after three mismatches, relock on the good stream
        for (int i = 0; i < 3; i++) send_bad(1'b0);
        check("t3_cnt", {24'd0, err_cnt}, 32'd4);
        check("t3_lost", {31'd0, locked}, 32'd0);
        for (int i = 0; i < 4; i++) send_good();
        check("t3_hunting", {31'd0, locked}, 32'd0);
        send_good();
        check("t3_relocked", {31'd0, locked}, 32'd1);
        check("t3_cnt_held", {24'd0, err_cnt}, 32'd4);

        // 4: gaps between valid samples
        do_reset();
        g = 4'h0;
        drive(g, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            gap($urandom_range(1, 3));
            check("t4_progress", {31'd0, locked}, 32'd0);
            send_good();
        end
        check("t4_locked", {31'd0, locked}, 32'd1);
        gap(2);
        check("t4_hold", {31'd0, locked}, 32'd1);

        // 5: lockup word repeated
        do_reset();
        for (int i = 0; i < 8; i++) begin
            drive(4'hF, 1'b1, 1'b0);
`ifndef LFSR_CHK_STUCK_EN
            if (i == 3) check("t5_not_yet", {31'd0, locked}, 32'd0);
            if (i == 4) check("t5_locked", {31'd0, locked}, 32'd1);
`endif
        end
`ifdef LFSR_CHK_STUCK_EN
        check("t5_stuck", {31'd0, stuck}, 32'd1);
        check("t5_no_lock", {31'd0, locked}, 32'd0);
`else
        check("t5_stuck", {31'd0, stuck}, 32'd0);
        check("t5_no_err", {24'd0, err_cnt}, 32'd0);
`endif

        // 6: clear beats a same-cycle mismatch; reset while locked
        do_reset();
        lock_from_zero();
        send_bad(1'b0);
        send_good();
        check("t6_pre_cnt", {24'd0, err_cnt}, 32'd1);
        send_bad(1'b1);
        check("t6_clr_cnt", {24'd0, err_cnt}, 32'd0);
        check("t6_clr_err", {31'd0, err}, 32'd1);
        send_good();
        check("t6_locked", {31'd0, locked}, 32'd1);
        do_reset();
        check("t6_rst_locked", {31'd0, locked}, 32'd0);
        check("t6_rst_state", 32'(fsm_state), 32'(ST_HUNT));
        check("t6_rst_err", {31'd0, err}, 32'd0);

        // saturation: two mismatches then a good word keeps the lock
        lock_from_zero();
        for (int i = 0; i < 135; i++) begin
            send_bad(1'b0);
            send_bad(1'b0);
            send_good();
        end
        check("sat_cnt", {24'd0, err_cnt}, 32'hFF);
        check("sat_locked", {31'd0, locked}, 32'd1);
        send_bad(1'b0);
        check("sat_hold", {24'd0, err_cnt}, 32'hFF);
        send_good();

        // random mix against the model
        base = checks;
        n    = 0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                drive(4'($urandom_range(0, 15)), 1'b0, ($urandom_range(0, 19) == 0));
            end else if ($urandom_range(0, 5) == 0) begin
                send_bad($urandom_range(0, 19) == 0);
            end else begin
                g = nxt(g);
                drive(g, 1'b1, ($urandom_range(0, 19) == 0));
            end
            n++;
        end
        check("rand_samples", 32'(checks - base), 32'(n * 6));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
